// File: rtl/frame_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : frame_encoder
//  Purpose  : Host-side framer: FF sync, control byte, echo check, clamped
//             sample stream, FF terminator. FRAME_LIMIT_EN caps samples/frame.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_encoder #(
  parameter int ACK_TIMEOUT = 1024,
  parameter int TMR_W       = 11
`ifdef FRAME_LIMIT_EN
  ,
  parameter int MAX_SAMPLES = 4096
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] ctrl_word,
  input  logic       stop,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic [7:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] ack_data,
  input  logic       ack_valid,
  output logic       busy,
  output logic       ack_ok,
  output logic       ack_err,
  output logic       ack_timeout,
  output logic       done
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_SYNC   = 3'd1;
  localparam logic [2:0] c_ST_CTRL   = 3'd2;
  localparam logic [2:0] c_ST_WAIT   = 3'd3;
  localparam logic [2:0] c_ST_STREAM = 3'd4;
  localparam logic [2:0] c_ST_TERM   = 3'd5;

  localparam logic [7:0]       c_SYNC_BYTE = 8'hFF;
  localparam logic [7:0]       c_CLAMP_MAX = 8'hFE;
  localparam logic [TMR_W-1:0] c_TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [7:0]       r_ctrl;
  logic [7:0]       r_data_out;
  logic             r_out_valid;
  logic [TMR_W-1:0] r_timer;
  logic             r_ack_ok;
  logic             r_ack_err;
  logic             r_ack_timeout;
  logic             r_done;

  logic       w_accept;
  logic       w_take;
  logic       w_limit;
  logic       w_ack_match;
  logic       w_sample_ready;
  logic [7:0] w_clamped;

`ifdef FRAME_LIMIT_EN
  localparam int c_CNT_W = $clog2(MAX_SAMPLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_SAMPLES);

  logic [c_CNT_W-1:0] r_sample_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample_cnt <= '0;
    end else if (w_ack_match) begin
      r_sample_cnt <= '0;
    end else if (w_take) begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
    end
  end

  assign w_limit = (r_sample_cnt == c_CNT_MAX);
`else
  assign w_limit = 1'b0;
`endif

  assign w_accept    = r_out_valid && out_ready;
  assign w_ack_match = (r_state == c_ST_WAIT) && ack_valid && (ack_data == r_ctrl);
  // 0xFF in the sample region would end the frame early at the decoder
  assign w_clamped   = (sample_in == 8'hFF) ? c_CLAMP_MAX : sample_in;

  assign w_sample_ready = (r_state == c_ST_STREAM) && !stop && !w_limit &&
                          (!r_out_valid || out_ready);
  assign w_take         = sample_valid && w_sample_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= c_ST_IDLE;
      r_ctrl        <= 8'h00;
      r_data_out    <= 8'h00;
      r_out_valid   <= 1'b0;
      r_timer       <= '0;
      r_ack_ok      <= 1'b0;
      r_ack_err     <= 1'b0;
      r_ack_timeout <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_ctrl        <= ctrl_word;
            r_ack_ok      <= 1'b0;
            r_ack_err     <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_data_out    <= c_SYNC_BYTE;
            r_out_valid   <= 1'b1;
            r_state       <= c_ST_SYNC;
          end
        end
        c_ST_SYNC: begin
          if (w_accept) begin
            r_data_out <= r_ctrl;
            r_state    <= c_ST_CTRL;
          end
        end
        c_ST_CTRL: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_timer     <= '0;
            r_state     <= c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // an echo arriving in the expiry cycle still counts
          if (ack_valid) begin
            if (ack_data == r_ctrl) begin
              r_ack_ok <= 1'b1;
              r_state  <= c_ST_STREAM;
            end else begin
              r_ack_err <= 1'b1;
              r_state   <= c_ST_IDLE;
            end
          end else if (r_timer == c_TMR_LAST) begin
            r_ack_timeout <= 1'b1;
            r_state       <= c_ST_IDLE;
          end
        end
        c_ST_STREAM: begin
          if (w_take) begin
            r_data_out  <= w_clamped;
            r_out_valid <= 1'b1;
          end else if ((stop || w_limit) && (!r_out_valid || out_ready)) begin
            r_data_out  <= c_SYNC_BYTE;
            r_out_valid <= 1'b1;
            r_state     <= c_ST_TERM;
          end else if (w_accept) begin
            r_out_valid <= 1'b0;
          end
        end
        c_ST_TERM: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= c_ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign sample_ready = w_sample_ready;
  assign data_out     = r_data_out;
  assign out_valid    = r_out_valid;
  assign busy         = (r_state != c_ST_IDLE);
  assign ack_ok       = r_ack_ok;
  assign ack_err      = r_ack_err;
  assign ack_timeout  = r_ack_timeout;
  assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_frame_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_encoder
//  Purpose  : Scoreboard bench for frame_encoder (ACK_TIMEOUT=8, MAX_SAMPLES=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] ctrl_word = 8'h00;
  logic       stop = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] ack_data = 8'h00;
  logic       ack_valid = 1'b0;
  logic       busy, ack_ok, ack_err, ack_timeout, done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_done  = 0;
  logic [7:0] exp_q[$];
  bit toggle_rdy = 1'b0;
  bit watch_sr   = 1'b0;
  bit sr_seen    = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  frame_encoder #(
    .ACK_TIMEOUT(8),
    .TMR_W(4)
`ifdef FRAME_LIMIT_EN
    ,
    .MAX_SAMPLES(3)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl_word(ctrl_word), .stop(stop),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .ack_data(ack_data), .ack_valid(ack_valid), .busy(busy), .ack_ok(ack_ok),
    .ack_err(ack_err), .ack_timeout(ack_timeout), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Link monitor: pops the scoreboard on every accepted byte
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(data_out), 32'(prev_data));
      end
      if (done) n_done++;
      if (watch_sr && sample_ready) sr_seen = 1'b1;
      if (out_valid && out_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL link_byte: got %02h, expected no byte", data_out);
        end else begin
          check("link_byte", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = data_out;
    end
  end

  always @(posedge clk) begin
    #1;
    if (toggle_rdy) out_ready = ~out_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_frame(input logic [7:0] ctrl, input logic [7:0] echo,
                            input int delay, input bit do_ack);
    int base = n_acc;
    int k = 0;
    exp_q.push_back(8'hFF);
    exp_q.push_back(ctrl);
    ctrl_word = ctrl;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (n_acc < base + 2 && k < 200) begin
      tick();
      k++;
    end
    check("ctrl_sent", 32'(n_acc >= base + 2), 32'd1);
    if (do_ack) begin
      repeat (delay - 1) tick();
      ack_data  = echo;
      ack_valid = 1'b1;
      tick();
      ack_valid = 1'b0;
    end
  endtask

  task automatic send_sample(input logic [7:0] v, input logic [7:0] e, input bit push);
    bit got = 1'b0;
    int k = 0;
    if (push) exp_q.push_back(e);
    sample_in    = v;
    sample_valid = 1'b1;
    while (!got && k < 200) begin
      @(negedge clk);
      got = sample_ready;
      tick();
      k++;
    end
    sample_valid = 1'b0;
    check("sample_taken", 32'(got), 32'd1);
  endtask

  task automatic close_frame(input bit use_stop);
    int d0 = n_done;
    int k = 0;
    exp_q.push_back(8'hFF);
    stop = use_stop;
    while (n_done == d0 && k < 200) begin
      tick();
      k++;
    end
    stop = 1'b0;
    repeat (3) tick();
    check("done_once", 32'(n_done - d0), 32'd1);
    check("idle_after", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) tick();
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sready", 32'(sample_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'({ack_ok, ack_err, ack_timeout, done}), 32'd0);
    rst = 1'b1;
    tick();

    // Basic frame: FF,5A,01..04,FF
    open_frame(8'h5A, 8'h5A, 3, 1'b1);
    check("basic_ack_ok", 32'(ack_ok), 32'd1);
    for (int i = 1; i <= 4; i++) send_sample(8'(i), 8'(i), 1'b1);
    close_frame(1'b1);
    check("basic_ack_sticky", 32'(ack_ok), 32'd1);

    // Clamp under toggling backpressure: FF,33,FE,80,FF
    toggle_rdy = 1'b1;
    open_frame(8'h33, 8'h33, 3, 1'b1);
    send_sample(8'hFF, 8'hFE, 1'b1);
    send_sample(8'h80, 8'h80, 1'b1);
    close_frame(1'b1);
    toggle_rdy = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();

    // Echo mismatch: no samples, no terminator
    watch_sr = 1'b1;
    sr_seen = 1'b0;
    sample_in = 8'h55;
    sample_valid = 1'b1;
    open_frame(8'h12, 8'h13, 3, 1'b1);
    check("mm_ack_err", 32'(ack_err), 32'd1);
    check("mm_ack_ok", 32'(ack_ok), 32'd0);
    repeat (5) tick();
    check("mm_idle", 32'(busy), 32'd0);
    check("mm_no_sready", 32'(sr_seen), 32'd0);
    check("mm_no_term", 32'(exp_q.size()), 32'd0);
    sample_valid = 1'b0;
    watch_sr = 1'b0;

    // Timeout exactly 8 cycles after entering WAIT_ACK
    open_frame(8'h21, 8'h00, 0, 1'b0);
    repeat (7) tick();
    check("to_not_yet", 32'(ack_timeout), 32'd0);
    tick();
    check("to_fired", 32'(ack_timeout), 32'd1);
    check("to_idle", 32'(busy), 32'd0);

    // Echo in the expiry cycle wins
    open_frame(8'h2C, 8'h2C, 8, 1'b1);
    check("late_ack_ok", 32'(ack_ok), 32'd1);
    check("late_no_to", 32'(ack_timeout), 32'd0);
    check("late_busy", 32'(busy), 32'd1);
    close_frame(1'b1);

    // Async reset mid-stream with a byte pending
    open_frame(8'h44, 8'h44, 3, 1'b1);
    out_ready = 1'b0;
    send_sample(8'h09, 8'h09, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(data_out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_flags", 32'({ack_ok, ack_err, ack_timeout, done, sample_ready}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    open_frame(8'h66, 8'h66, 3, 1'b1);
    close_frame(1'b1);

`ifdef FRAME_LIMIT_EN
    // Auto-terminate after 3 samples: FF,77,10,11,12,FF
    open_frame(8'h77, 8'h77, 3, 1'b1);
    for (int i = 0; i < 3; i++) send_sample(8'h10 + 8'(i), 8'h10 + 8'(i), 1'b1);
    watch_sr = 1'b1;
    sr_seen = 1'b0;
    sample_in = 8'h13;
    sample_valid = 1'b1;
    close_frame(1'b0);
    sample_valid = 1'b0;
    watch_sr = 1'b0;
    check("limit_no_sready", 32'(sr_seen), 32'd0);
`endif

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_encoder.md
Name: frame_encoder

Overview:
- Host/controller-side framer that produces the byte stream consumed by the sample decoder on the modulator side.
- Per frame it emits a sync byte 0xFF and one control byte, then waits for the decoder to echo the control byte back.
- After the echo it streams samples, and closes the frame with a 0xFF terminator.
- Sample value 0xFF is clamped to 0xFE, because 0xFF in the sample stream ends the frame at the decoder.

Parameters:
- ACK_TIMEOUT, 1024, number of clk cycles to wait in WAIT_ACK before aborting (≥2).
- TMR_W, 11, timer width; must hold ACK_TIMEOUT.
- MAX_SAMPLES, 4096, samples per frame before auto-terminate (only with FRAME_LIMIT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-low
- start  in  1  begin frame; sampled only in IDLE
- ctrl_word  in  8  control byte, latched on accepted start
- stop  in  1  request terminator; level, sampled in STREAM
- sample_in  in  8  sample data
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  sample accepted when sample_valid && sample_ready
- data_out  out  8  byte to link/decoder
- out_valid  out  1  data_out valid; held until accepted
- out_ready  in  1  link accepts byte when out_valid && out_ready
- ack_data  in  8  echo byte from decoder
- ack_valid  in  1  one-cycle strobe qualifying ack_data
- busy  out  1  state != IDLE
- ack_ok  out  1  sticky: echo matched
- ack_err  out  1  sticky: echo mismatched
- ack_timeout  out  1  sticky: no echo within ACK_TIMEOUT
- done  out  1  one-cycle pulse when the terminator is accepted

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - data_out=0, out_valid=0, sample_ready=0, busy=0.
  - ack_ok=ack_err=ack_timeout=0, done=0.
  - ctrl_reg=0, timer=0, sample counter=0.
  - Reset mid-frame aborts immediately; no terminator is sent.
- Byte handshake:
  - data_out is registered and stays stable while out_valid=1 && out_ready=0.
  - out_valid never drops without acceptance, except on reset.
- IDLE: start=1 → latch ctrl_reg=ctrl_word, clear the three sticky flags, go SYNC. Next cycle data_out=0xFF, out_valid=1.
- SYNC: on accept → go CTRL; data_out=ctrl_reg, out_valid=1 next cycle.
- CTRL: on accept → go WAIT_ACK; out_valid=0, timer=0.
- WAIT_ACK: timer increments each cycle.
  - ack_valid && ack_data==ctrl_reg → ack_ok=1, go STREAM.
  - ack_valid && mismatch → ack_err=1, go IDLE.
  - timer==ACK_TIMEOUT-1 with no ack_valid → ack_timeout=1, go IDLE.
  - If ack_valid and expiry fall in the same cycle, ack_valid wins.
  - ack_valid in any other state is ignored.
- STREAM:
  - sample_ready = (state==STREAM) && !stop && (!out_valid || out_ready). This is combinational from registered state and inputs.
  - Accepted sample → data_out = (sample_in==0xFF) ? 0xFE : sample_in, out_valid=1 next cycle. Zero-bubble throughput of 1 byte/cycle when out_ready is held high.
  - stop=1: no new samples are taken. Once no byte is pending (out_valid=0, or the current byte is accepted), go TERM with data_out=0xFF, out_valid=1.
  - If stop and sample_valid are asserted in the same cycle, stop wins and the sample is not accepted.
- TERM: on accept → done=1 for one cycle, out_valid=0, go IDLE.
- start outside IDLE is ignored.
- Byte order on the link per frame: FF, ctrl, [samples…], FF. 0xFF never appears in the sample region.

Optional Feature:
- Macro: FRAME_LIMIT_EN.
- Defined:
  - A sample counter (width ceil(log2(MAX_SAMPLES+1))) is cleared on entering STREAM and increments per accepted sample.
  - When it reaches MAX_SAMPLES, sample_ready forces 0 and the terminator is sent as if stop were asserted.
  - stop still terminates earlier.
- Not defined: no counter; only stop ends a frame; MAX_SAMPLES unused.

Test Plan:
- Basic frame: start with ctrl_word=0x5A, out_ready=1, decoder model echoes 0x5A 3 cycles after the ctrl byte, 4 samples 0x01..0x04, then stop → link bytes FF,5A,01,02,03,04,FF; ack_ok=1; done pulses once; busy low afterwards.
- Clamp/backpressure: stream 0xFF,0x80 with out_ready toggling 1/0 every cycle → link sees FE,80; data_out stable while stalled; no sample lost or duplicated.
- Echo mismatch: ctrl 0x12, echo 0x13 → ack_err=1, returns to IDLE, no samples taken (sample_ready stays 0), no terminator.
- Timeout: ACK_TIMEOUT=8, no echo → ack_timeout=1 exactly 8 cycles after entering WAIT_ACK; an echo strobed in the expiry cycle instead gives ack_ok=1 and ack_timeout=0.
- Async reset mid-STREAM with out_valid=1 → all outputs 0 immediately; next start produces a clean FF,ctrl sequence.
- With FRAME_LIMIT_EN, MAX_SAMPLES=3, continuous sample_valid and no stop → link bytes FF,ctrl,s0,s1,s2,FF; sample_ready low from the 4th sample on.
